// File: rtl/alu_4bit_ctrl.sv
// Instruction-issuing controller for the 4-bit ALU.
// Reads a 4x4 register file, drives A/B/s, and writes back Y.
module alu_4bit_ctrl #(
  parameter logic [3:0] DZ_VALUE = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] in_instr,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_s,
  input  logic [3:0] alu_y,
  output logic       res_valid,
  output logic [3:0] res_data,
  output logic       res_zero,
  output logic       res_dz,
  input  logic [1:0] dbg_addr,
  output logic [3:0] dbg_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic [3:0] rf [4];
  logic [2:0] op_q;
  logic [1:0] rd_q;
  logic [3:0] imm_q;
  logic [3:0] wdata;
  logic       dz;

  assign in_ready = (state == IDLE);
  assign dbg_data = rf[dbg_addr];

  // ALU output is undefined for a zero divisor and unused for LOADI
  always_comb begin
    wdata = alu_y;
    dz    = 1'b0;
    unique case (1'b1)
      (op_q == 3'b111): wdata = imm_q;
      (op_q == 3'b011 && alu_b == 4'd0): begin
        wdata = DZ_VALUE;
        dz    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      for (int i = 0; i < 4; i++) rf[i] <= 4'd0;
      op_q      <= 3'd0;
      rd_q      <= 2'd0;
      imm_q     <= 4'd0;
      alu_a     <= 4'd0;
      alu_b     <= 4'd0;
      alu_s     <= 3'd0;
      res_valid <= 1'b0;
      res_data  <= 4'd0;
      res_zero  <= 1'b0;
      res_dz    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_q  <= in_instr[8:6];
            rd_q  <= in_instr[5:4];
            imm_q <= in_instr[3:0];
            alu_a <= rf[in_instr[3:2]];
            alu_b <= rf[in_instr[1:0]];
            alu_s <= in_instr[8:6];
            state <= EXEC;
          end
        end
        EXEC: begin
          rf[rd_q]  <= wdata;
          res_data  <= wdata;
          res_zero  <= (wdata == 4'd0);
          res_dz    <= dz;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_4bit_ctrl.sv
// Bench for alu_4bit_ctrl: ALU model, register-file model and a
// result scoreboard checked on every res_valid pulse.
module tb_alu_4bit_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_instr;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_s;
  logic [3:0] alu_y;
  logic       res_valid;
  logic [3:0] res_data;
  logic       res_zero;
  logic       res_dz;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;

  typedef struct packed {
    logic [3:0] d;
    logic       z;
    logic       dz;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] rf_m [4];
  int         n_checks;
  int         n_errors;

  alu_4bit_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
    .res_valid(res_valid), .res_data(res_data),
    .res_zero(res_zero), .res_dz(res_dz),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench ALU; zero divisor returns junk so the DUT must override it
  function automatic logic [3:0] alu_f(
    input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    logic [7:0] p;
    p = {4'd0, a} * {4'd0, b};
    case (s)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return p[3:0];
      3'd3: return (b == 4'd0) ? 4'h7 : a / b;
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return a ^ b;
      default: return 4'd0;
    endcase
  endfunction

  assign alu_y = alu_f(alu_a, alu_b, alu_s);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_res_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_data", 32'(res_data), 32'(e.d));
        chk("res_zero", 32'(res_zero), 32'(e.z));
        chk("res_dz", 32'(res_dz), 32'(e.dz));
      end
    end
  end

  // Update the register-file model and push the expected result
  task automatic model(input logic [8:0] ins);
    logic [2:0] op;
    logic [3:0] a, b, w;
    logic       dz;
    exp_t       e;
    op = ins[8:6];
    a  = rf_m[ins[3:2]];
    b  = rf_m[ins[1:0]];
    dz = 1'b0;
    if (op == 3'b111) w = ins[3:0];
    else if (op == 3'b011 && b == 4'd0) begin
      w  = 4'hF;
      dz = 1'b1;
    end else w = alu_f(a, b, op);
    rf_m[ins[5:4]] = w;
    e.d  = w;
    e.z  = (w == 4'd0);
    e.dz = dz;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after writeback
  task automatic issue(input logic [8:0] ins);
    int         t;
    logic [3:0] a, b;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("ready_timeout", 32'd0, 32'd1);
    a = rf_m[ins[3:2]];
    b = rf_m[ins[1:0]];
    in_valid = 1'b1;
    in_instr = ins;
    model(ins);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_instr = 9'($urandom);
    @(negedge clk);
    chk("exec_alu_s", 32'(alu_s), 32'(ins[8:6]));
    chk("exec_alu_a", 32'(alu_a), 32'(a));
    chk("exec_alu_b", 32'(alu_b), 32'(b));
    chk("exec_ready", 32'(in_ready), 32'd0);
    chk("exec_no_valid", 32'(res_valid), 32'd0);
    in_instr = 9'($urandom);
    #2;
    chk("exec_alu_a_hold", 32'(alu_a), 32'(a));
    chk("exec_alu_b_hold", 32'(alu_b), 32'(b));
    @(negedge clk);
    chk("latency_valid", 32'(res_valid), 32'd1);
  endtask

  task automatic dbg_chk(input logic [1:0] r);
    dbg_addr = r;
    #1;
    chk("dbg_data", 32'(dbg_data), 32'(rf_m[r]));
  endtask

  task automatic chk_reset_outs();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_s", 32'(alu_s), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_zero", 32'(res_zero), 32'd0);
    chk("rst_res_dz", 32'(res_dz), 32'd0);
  endtask

  initial begin
    logic [8:0] ins;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_instr = 9'd0;
    dbg_addr = 2'd0;
    for (int i = 0; i < 4; i++) rf_m[i] = 4'd0;

    #12;
    chk_reset_outs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_no_valid", 32'(res_valid), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd1);

    issue(9'b111_01_10_01);
    issue(9'b111_10_10_00);
    issue(9'b000_11_01_10);
    dbg_chk(2'd3);

    issue(9'b111_01_00_10);
    issue(9'b111_10_00_11);
    issue(9'b001_00_01_10);
    issue(9'b010_00_01_10);
    issue(9'b110_01_01_01);
    dbg_chk(2'd1);

    issue(9'b111_10_00_00);
    issue(9'b011_11_01_10);
    dbg_chk(2'd3);
    issue(9'b111_01_10_01);
    issue(9'b111_10_00_10);
    issue(9'b011_00_01_10);
    dbg_chk(2'd0);

    // Mid-run reset while idle clears outputs and the register file
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outs();
    for (int i = 0; i < 4; i++) rf_m[i] = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) dbg_chk(2'(r));

    // Continuous in_valid: only instructions on IDLE edges are taken
    for (int k = 0; k < 9; k++) begin
      ins = {3'b111, 2'(k), 4'(k + 1)};
      in_valid = 1'b1;
      in_instr = ins;
      chk("hs_ready", 32'(in_ready), 32'((k % 3) == 0));
      if ((k % 3) == 0) model(ins);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int r = 0; r < 4; r++) dbg_chk(2'(r));

    // Reset during EXEC aborts the ADD with no writeback
    issue(9'b111_01_00_11);
    issue(9'b111_10_01_01);
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    in_instr = 9'b000_11_01_10;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_res_valid", 32'(res_valid), 32'd0);
    for (int i = 0; i < 4; i++) rf_m[i] = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int r = 0; r < 4; r++) dbg_chk(2'(r));
    issue(9'b111_11_01_01);
    dbg_chk(2'd3);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_4bit_ctrl.md
Name: alu_4bit_ctrl

Overview:
Instruction-issuing controller for the 4-bit combinational ALU: the initiator side of the ALU's A/B/s→Y interface. It accepts 9-bit instructions over a valid/ready handshake and reads operands from an internal 4×4-bit register file. It drives the ALU operand and select ports, captures the ALU result, writes it back, and reports status. It sits between an instruction source (testbench or sequencer) and one alu_4_bit instance.

Parameters:
DZ_VALUE, 4'hF, value written to rd when a divide (op 3'b011) has a zero divisor.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction valid
in_ready  output  1  controller can accept an instruction
in_instr  input  9  instruction: [8:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2
alu_a  output  4  ALU operand A (registered)
alu_b  output  4  ALU operand B (registered)
alu_s  output  3  ALU select (registered)
alu_y  input  4  ALU result (combinational from alu_a/alu_b/alu_s)
res_valid  output  1  one-cycle pulse: writeback done
res_data  output  4  value written to rd
res_zero  output  1  res_data == 0, valid with res_valid
res_dz  output  1  divide-by-zero occurred, valid with res_valid
dbg_addr  input  2  register-file debug read address
dbg_data  output  4  rf[dbg_addr], combinational

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; rf[0..3]=0; alu_a/alu_b=0; alu_s=3'b000; res_valid=0; res_data=0; res_zero=0; res_dz=0. in_ready is 1 out of reset (IDLE).
- FSM states: IDLE → EXEC → DONE → IDLE.
- IDLE: in_ready=1. On a clk edge with in_valid=1:
  - latch op/rd/rs2.
  - alu_a<=rf[rs1], alu_b<=rf[rs2], alu_s<=op.
  - go to EXEC.
  - No accept happens without in_valid; the FSM stays in IDLE.
- EXEC: in_ready=0. alu_y is sampled at the end-of-EXEC edge:
  - op 000–110: wdata=alu_y.
  - op 011 with alu_b==0: wdata=DZ_VALUE and dz=1. alu_y is ignored, because the ALU output is undefined for a zero divisor.
  - op 111 (LOADI): wdata={rs1,rs2} as a 4-bit immediate. alu_y is ignored (the ALU returns 0 for this select).
  - At that edge: rf[rd]<=wdata, res_data<=wdata, res_zero<=(wdata==0), res_dz<=dz, res_valid<=1. Go to DONE.
- DONE: in_ready=0. res_valid=1 for exactly this cycle. Next edge: res_valid<=0, go to IDLE. res_data/res_zero/res_dz hold until the next writeback.
- Latency: accept edge → res_valid high after 2 edges. Throughput: one instruction per 3 cycles.
- Arithmetic is 4-bit modulo, as computed by the ALU:
  - add wraps (e.g., 9+8=1).
  - sub wraps (e.g., 2-3=15).
  - mul keeps the low 4 bits.
  - div is an integer quotient.
- rd may equal rs1 or rs2. Operands are captured at accept, so the write is not visible to that same instruction.
- alu_a/alu_b/alu_s hold their values after EXEC until the next accept. They never change during EXEC.
- in_instr changes while in_ready=0 are ignored.
- dbg_data reflects the new rf contents from the cycle after the write edge.
- rst_n asserted in EXEC or DONE: the instruction is aborted with no writeback, all state is cleared, and in_ready=1 immediately (asynchronously).

Test Plan:
- Reset then idle: rst_n low mid-run → all outputs 0 and in_ready=1. Hold in_valid=0 for 10 cycles → res_valid stays 0.
- LOADI r1=9 (9'b111_01_10_01), LOADI r2=8, then ADD r3=r1+r2 (9'b000_11_01_10) → res_data=1, res_zero=0. dbg_addr=3 → dbg_data=1. res_valid occurs 2 edges after each accept.
- r1=2, r2=3: SUB r0=r1-r2 → 15. MUL r0=r1*r2 → 6. XOR r1=r1^r1 → 0 with res_zero=1. While each instruction is executing: alu_s matches op and alu_a/alu_b hold steady.
- DIV with r2=0 → res_data=4'hF, res_dz=1, rf[rd]=4'hF. Then DIV r=9/2 → res_data=4, res_dz=0.
- Handshake: in_valid held high continuously with changing in_instr → in_ready pattern is 1,0,0 repeating. Only instructions present on IDLE edges execute, one per 3 cycles.
- rst_n pulsed during EXEC of an ADD → no res_valid pulse, rf[rd] reads 0, next LOADI completes normally.
